lvds_word_aligner: RTL

- Parametrised successor to the fixed 6-beat, 48-bit sensor deserialiser gearbox.
- Sits in the I_clk domain after the per-lane IDDR and the clock-domain-crossing FIFO.
- Packs LANES×2-bit beats into OUT_W-bit words at a selectable beat offset.
- Finds that offset automatically by searching for a training pattern, then verifies and locks it. A manual slip mode is kept alongside.

---
 rtl/lvds_align_pkg.sv | 22 ++
 rtl/lvds_align_fsm.sv | 160 ++++++++++++++++
 rtl/lvds_word_aligner.sv | 89 ++++++++
 3 files changed

// File: rtl/lvds_align_pkg.sv
// Shared constants for the LVDS word aligner: FSM state codes, the default
// training word and a constant-safe ceiling log2.
package lvds_align_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_VERIFY = 2'd2;
   localparam logic [1:0] ST_LOCKED = 2'd3;

   localparam logic [47:0] DEFAULT_TRAIN_PATTERN = 48'hA5C3_0F96_E17B;

   // Ceiling log2 with a floor of 1 bit, so single-value counters still get a port width.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/lvds_align_fsm.sv
// Alignment controller: walks the beat offset until the training word is seen
// LOCK_CNT times in a row, then holds that offset while the word keeps matching.
module lvds_align_fsm
   import lvds_align_pkg::*;
#(
   parameter int  WORD_BEATS = 6,
   parameter int  LOCK_CNT   = 4,
   parameter int  MISS_LIMIT = 3,
   localparam int OFS_W      = clog2(WORD_BEATS)
) (
   input  logic             I_clk,
   input  logic             I_rstn,
   input  logic             I_train,
   input  logic             I_slip,
   input  logic             I_boundary,
   input  logic             I_match,
   output logic [OFS_W-1:0] O_offset,
   output logic             O_locked,
   output logic             O_align_err,
   output logic [1:0]       O_state
);

   localparam int MC_W    = clog2(LOCK_CNT);
   localparam int MISS_W  = clog2(MISS_LIMIT);
   localparam int SWEEP_W = clog2(2 * WORD_BEATS);

   localparam logic [OFS_W-1:0]   OFS_LAST   = OFS_W'(WORD_BEATS - 1);
   localparam logic [MC_W-1:0]    MC_LAST    = MC_W'(LOCK_CNT - 1);
   localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(MISS_LIMIT - 1);
   localparam logic [SWEEP_W-1:0] SWEEP_LAST = SWEEP_W'(2 * WORD_BEATS - 1);

   logic [1:0]         state_q,  state_d;
   logic [OFS_W-1:0]   offset_q, offset_d;
   logic [MC_W-1:0]    mc_q,     mc_d;
   logic [MISS_W-1:0]  miss_q,   miss_d;
   logic [SWEEP_W-1:0] sweep_q,  sweep_d;
   logic               err_q,    err_d;
   logic [OFS_W-1:0]   ofs_inc;

   assign ofs_inc = (offset_q == OFS_LAST) ? '0 : offset_q + 1'b1;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path through the case infers a latch.
      state_d  = state_q;
      offset_d = offset_q;
      mc_d     = mc_q;
      miss_d   = miss_q;
      sweep_d  = sweep_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE: begin
            if (I_slip) offset_d = ofs_inc;
            if (I_train) begin
               state_d = ST_SEARCH;
               sweep_d = '0;
               mc_d    = '0;
            end
         end

         ST_SEARCH: begin
            if (!I_train) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
               sweep_d = '0;
            end else if (I_boundary) begin
               if (I_match) begin
                  sweep_d = '0;
                  if (LOCK_CNT == 1) begin
                     state_d = ST_LOCKED;
                     err_d   = 1'b0;
                     miss_d  = '0;
                  end else begin
                     state_d = ST_VERIFY;
                     mc_d    = MC_W'(1);
                  end
               end else begin
                  offset_d = ofs_inc;
                  // Two full sweeps without a hit: flag it and keep hunting.
                  if (sweep_q == SWEEP_LAST) begin
                     err_d   = 1'b1;
                     sweep_d = '0;
                  end else begin
                     sweep_d = sweep_q + 1'b1;
                  end
               end
            end
         end

         ST_VERIFY: begin
            if (!I_train) begin
               state_d = ST_IDLE;
               err_d   = 1'b0;
               mc_d    = '0;
            end else if (I_boundary) begin
               if (I_match) begin
                  if (mc_q == MC_LAST) begin
                     state_d = ST_LOCKED;
                     err_d   = 1'b0;
                     miss_d  = '0;
                     mc_d    = '0;
                  end else begin
                     mc_d = mc_q + 1'b1;
                  end
               end else begin
                  state_d  = ST_SEARCH;
                  offset_d = ofs_inc;
                  mc_d     = '0;
               end
            end
         end

         ST_LOCKED: begin
            if (I_slip) begin
               state_d  = ST_IDLE;
               offset_d = ofs_inc;
               miss_d   = '0;
            end else if (I_train && I_boundary) begin
               if (I_match) begin
                  miss_d = '0;
               end else if (miss_q == MISS_LAST) begin
                  state_d  = ST_SEARCH;
                  offset_d = ofs_inc;
                  miss_d   = '0;
                  sweep_d  = '0;
               end else begin
                  miss_d = miss_q + 1'b1;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         state_q  <= ST_IDLE;
         offset_q <= '0;
         mc_q     <= '0;
         miss_q   <= '0;
         sweep_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q  <= state_d;
         offset_q <= offset_d;
         mc_q     <= mc_d;
         miss_q   <= miss_d;
         sweep_q  <= sweep_d;
         err_q    <= err_d;
      end
   end

   assign O_offset    = offset_q;
   assign O_locked    = (state_q == ST_LOCKED);
   assign O_align_err = err_q;
   assign O_state     = state_q;

endmodule

// File: rtl/lvds_word_aligner.sv
// Gearbox from LANES x 2-bit DDR beats to OUT_W-bit words, with the beat offset
// chosen by lvds_align_fsm from a training pattern or by manual slips.
module lvds_word_aligner
   import lvds_align_pkg::*;
#(
   parameter int  LANES      = 4,
   parameter int  WORD_BEATS = 6,
   parameter logic [2*LANES*WORD_BEATS-1:0] TRAIN_PATTERN = DEFAULT_TRAIN_PATTERN,
   parameter int  LOCK_CNT   = 4,
   parameter int  MISS_LIMIT = 3,
   localparam int IN_W       = 2 * LANES,
   localparam int OUT_W      = IN_W * WORD_BEATS,
   localparam int OFS_W      = clog2(WORD_BEATS),
   localparam int SR_W       = (2 * WORD_BEATS - 1) * IN_W
) (
   input  logic             I_clk,
   input  logic             I_rstn,
   input  logic [IN_W-1:0]  I_data,
   input  logic             I_valid,
   input  logic             I_train,
   input  logic             I_slip,
   output logic [OUT_W-1:0] O_data,
   output logic             O_valid,
   output logic [OFS_W-1:0] O_offset,
   output logic             O_locked,
   output logic             O_align_err,
   output logic [1:0]       O_state
);

   localparam logic [OFS_W-1:0] BC_LAST = OFS_W'(WORD_BEATS - 1);

   logic [SR_W-1:0]  sr_q,   sr_d;
   logic [OFS_W-1:0] bc_q,   bc_d;
   logic [OUT_W-1:0] data_q, cand;
   logic             valid_q;
   logic             boundary;
   logic             match;
   logic [OFS_W-1:0] offset;

   // The word boundary is purely a beat count; offset changes only move the window.
   assign sr_d     = I_valid ? {sr_q[SR_W-IN_W-1:0], I_data} : sr_q;
   assign boundary = I_valid && (bc_q == BC_LAST);
   assign bc_d     = !I_valid ? bc_q : ((bc_q == BC_LAST) ? '0 : bc_q + 1'b1);

   always_comb begin
      cand = sr_d[OUT_W-1:0];
      for (int k = 1; k < WORD_BEATS; k++) begin
         if (offset == OFS_W'(k)) cand = sr_d[k*IN_W +: OUT_W];
      end
   end

   assign match = (cand == TRAIN_PATTERN);

   always_ff @(posedge I_clk or negedge I_rstn) begin
      if (!I_rstn) begin
         sr_q    <= '0;
         bc_q    <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         bc_q    <= bc_d;
         valid_q <= boundary;
         if (boundary) data_q <= cand;
      end
   end

   lvds_align_fsm #(
      .WORD_BEATS (WORD_BEATS),
      .LOCK_CNT   (LOCK_CNT),
      .MISS_LIMIT (MISS_LIMIT)
   ) u_fsm (
      .I_clk       (I_clk),
      .I_rstn      (I_rstn),
      .I_train     (I_train),
      .I_slip      (I_slip),
      .I_boundary  (boundary),
      .I_match     (match),
      .O_offset    (offset),
      .O_locked    (O_locked),
      .O_align_err (O_align_err),
      .O_state     (O_state)
   );

   assign O_data   = data_q;
   assign O_valid  = valid_q;
   assign O_offset = offset;

endmodule
